life_sequencer: RTL and testbench
=================================

Name: life_sequencer

Overview:
- Run controller for the 16x16 toroidal Conway life grid, which has no enable and steps every clock while its load input is low.
- Sits between a host command interface and the grid's load/data/q ports.
- Supports seed loading, single-step, free-run at a programmable generation rate, and user stop.
- Stops automatically on extinction, still life or a generation limit, and reports the stop reason.

Parameters:
GEN_W  32  generation counter width
RATE_W  24  rate divider width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  2  0=LOAD, 1=STEP, 2=RUN, 3=STOP
seed  in  256  seed pattern, sampled on accepted LOAD
rate_div  in  RATE_W  RUN advances once every rate_div+1 RUN-state cycles
gen_limit  in  GEN_W  auto-stop generation count in RUN; 0 = unlimited
grid_q  in  256  current grid state
grid_load  out  1  to grid load
grid_data  out  256  to grid data
busy  out  1  state != IDLE
gen_count  out  GEN_W  generations advanced since last LOAD; saturates at all-ones
stop_valid  out  1  one-cycle pulse when the sequencer stops
stop_reason  out  3  0=USER, 1=EXTINCT, 2=STILL, 3=LIMIT, 4=OSC2; valid with stop_valid, held until next pulse

Behaviour:
- Hold mechanism: the grid is frozen by driving grid_load=1, grid_data=grid_q. An advance cycle is the only cycle with grid_load=0.
- grid_load/grid_data are combinational from state. In LOAD: grid_load=1, grid_data=seed_reg. In advance cycles: grid_load=0. In all other states: hold.
- Reset (async, any state): state=IDLE, gen_count=0, stop_valid=0, stop_reason=0, seed_reg=0, snapshots=0, div_cnt=0, hist_valid=0. Outputs hold the grid during and after reset.
- States: IDLE, LOAD, ADV, RUN, CHECK.
- cmd_ready=1 in IDLE and RUN only; 0 in LOAD, ADV, CHECK.
- IDLE:
  - LOAD: seed_reg<=seed, go to LOAD.
  - STEP: go to ADV.
  - RUN: div_cnt<=0, go to RUN.
  - STOP: accepted; no effect and no pulse.
- LOAD (1 cycle): grid takes seed_reg. gen_count<=0, hist_valid<=0, then IDLE.
- ADV (1 cycle, from STEP): grid_load=0, prev<=grid_q (pre-advance state), gen_count++, then CHECK, then IDLE.
- RUN:
  - Accepted STOP has priority: no advance in that cycle; go to IDLE; next cycle stop_valid=1 with reason 0.
  - Accepted LOAD/STEP/RUN: dropped, no effect.
  - Otherwise, if div_cnt==rate_div: advance this cycle (grid_load=0, prev<=grid_q, gen_count++, div_cnt<=0), then CHECK.
  - Else div_cnt++.
- Generation period in RUN is rate_div+2 cycles (rate_div+1 RUN cycles plus 1 CHECK cycle).
- CHECK (1 cycle; grid_q is the new generation). Priority order:
  - grid_q==0 -> EXTINCT.
  - grid_q==prev -> STILL.
  - OSC2 (macro only).
  - from RUN: gen_limit!=0 && gen_count>=gen_limit -> LIMIT.
- On any stop condition: stop_valid pulses this cycle, stop_reason is set, next state is IDLE.
- Otherwise: CHECK from ADV returns to IDLE with no pulse; CHECK from RUN returns to RUN with div_cnt=0.
- hist_valid<=1 and prev2<=prev at the end of each CHECK.
- gen_limit already reached on RUN entry: the first CHECK stops with LIMIT.
- A STEP is never limited.

Optional Feature:
LIFE_OSC2_DETECT_EN:
- Defined: keep prev2 (the state two generations back). In CHECK, hist_valid && grid_q==prev2 && grid_q!=prev -> stop with reason 4 (priority below STILL, above LIMIT).
- Undefined: prev2 and hist_valid are not built; reason 4 is never produced.

Test Plan:
- LOAD block {0,1,16,17}, STEP -> grid unchanged, stop_valid with reason 2, gen_count=1, busy low afterwards.
- LOAD single cell {0}, STEP -> grid_q=0, reason 1, gen_count=1.
- LOAD blinker {17,18,19}, RUN rate_div=3, gen_limit=5:
  - Without macro: grid toggles every 5 cycles; stop at gen_count=5, reason 3.
  - With LIFE_OSC2_DETECT_EN: stop at gen_count=2, reason 4.
- RUN rate_div=0; issue STOP in a RUN cycle that would advance -> grid_load stays 1, grid unchanged, reason 0 one cycle later, gen_count unchanged.
- Hold cmd_valid with STOP during CHECK -> cmd_ready=0 in CHECK; STOP accepted in the following RUN cycle.
- rst_n low mid-RUN -> state IDLE immediately, gen_count=0, grid_load=1 holds grid, no stop_valid pulse.

Source files
------------

// File: rtl/life_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : life_sequencer                                             |
// | Description : Run controller for a 16x16 toroidal Conway life grid. The  |
// |               grid has no enable and steps on every clock while its load |
// |               input is low. This block freezes the grid by reloading it  |
// |               with its own state and lets it advance only on chosen      |
// |               cycles. It supports seed load, single step, free-run at a  |
// |               programmable rate and user stop. It stops by itself on     |
// |               extinction, still life or a generation limit, and reports  |
// |               why it stopped.                                            |
// | Option      : `define LIFE_OSC2_DETECT_EN adds period-2 oscillator       |
// |               detection (stop reason 4).                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    host command request
//   cmd_ready    command accepted when cmd_valid && cmd_ready
//   cmd_op       0=LOAD 1=STEP 2=RUN 3=STOP
//   seed         seed pattern, captured on an accepted LOAD
//   rate_div     RUN advances once every rate_div+1 RUN cycles
//   gen_limit    generation count that stops a RUN (0 = unlimited)
//   grid_q       current grid state
//   grid_load    grid load strobe (0 only on advance cycles)
//   grid_data    grid load data
//   busy         sequencer is not idle
//   gen_count    generations advanced since the last LOAD (saturating)
//   stop_valid   one-cycle pulse when the sequencer stops
//   stop_reason  0=USER 1=EXTINCT 2=STILL 3=LIMIT 4=OSC2, held between pulses
// Bit k of a 256-bit grid vector is row k/16, column k%16.

module life_sequencer #(
  parameter int GEN_W  = 32,
  parameter int RATE_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [255:0]      seed,
  input  logic [RATE_W-1:0] rate_div,
  input  logic [GEN_W-1:0]  gen_limit,
  input  logic [255:0]      grid_q,
  output logic              grid_load,
  output logic [255:0]      grid_data,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count,
  output logic              stop_valid,
  output logic [2:0]        stop_reason
);

  // Command opcodes
  localparam logic [1:0] c_OP_LOAD = 2'd0;
  localparam logic [1:0] c_OP_STEP = 2'd1;
  localparam logic [1:0] c_OP_RUN  = 2'd2;
  localparam logic [1:0] c_OP_STOP = 2'd3;

  // Sequencer states
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_ADV   = 3'd2;
  localparam logic [2:0] c_ST_RUN   = 3'd3;
  localparam logic [2:0] c_ST_CHECK = 3'd4;

  // Stop reasons
  localparam logic [2:0] c_RSN_USER    = 3'd0;
  localparam logic [2:0] c_RSN_EXTINCT = 3'd1;
  localparam logic [2:0] c_RSN_STILL   = 3'd2;
  localparam logic [2:0] c_RSN_LIMIT   = 3'd3;
  localparam logic [2:0] c_RSN_OSC2    = 3'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [255:0]      r_seed;
  logic [255:0]      r_prev;         // grid as it was before the last advance
  logic [GEN_W-1:0]  r_gen_count;
  logic [RATE_W-1:0] r_div_cnt;
  logic              r_from_run;     // the pending CHECK was entered from RUN
  logic              r_user_stop;    // a user STOP was accepted last cycle
  logic [2:0]        r_stop_reason;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic [2:0] w_state_nxt;
  logic       w_ready;
  logic       w_accept;
  logic       w_user_stop;
  logic       w_run_adv;
  logic       w_advance;
  logic       w_extinct;
  logic       w_still;
  logic       w_osc2;
  logic       w_limit;
  logic       w_check_stop;
  logic [2:0] w_check_reason;

  // Commands are only taken while idle or free-running.
  assign w_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_RUN);
  assign w_accept = cmd_valid && w_ready;

  // A STOP taken in RUN wins over an advance due in the same cycle, so the
  // grid is never stepped on the cycle the host asked it to halt.
  assign w_user_stop = (r_state == c_ST_RUN) && w_accept && (cmd_op == c_OP_STOP);
  assign w_run_adv   = (r_state == c_ST_RUN) && !w_user_stop && (r_div_cnt == rate_div);
  assign w_advance   = (r_state == c_ST_ADV) || w_run_adv;

  // --------------------------------------------------------------------------
  // Stop-condition evaluation; only meaningful in CHECK, where grid_q is the
  // newly computed generation and r_prev is the one before it.
  // --------------------------------------------------------------------------
  assign w_extinct = (grid_q == '0);
  assign w_still   = (grid_q == r_prev);
  // A STEP is never limited, so the limit only applies to CHECKs out of RUN.
  assign w_limit   = r_from_run && (gen_limit != '0) && (r_gen_count >= gen_limit);

`ifdef LIFE_OSC2_DETECT_EN
  logic         r_hist_valid;        // r_prev2 holds a real generation
  logic [255:0] r_prev2;             // grid two generations back

  // Back to the state two generations ago, but not a still life.
  assign w_osc2 = r_hist_valid && (grid_q == r_prev2) && !w_still;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_valid <= 1'b0;
      r_prev2      <= '0;
    end else begin
      if (r_state == c_ST_LOAD) begin
        r_hist_valid <= 1'b0;
      end else if (r_state == c_ST_CHECK) begin
        r_hist_valid <= 1'b1;
        r_prev2      <= r_prev;
      end
    end
  end
`else
  assign w_osc2 = 1'b0;
`endif

  always_comb begin
    w_check_stop   = 1'b0;
    w_check_reason = c_RSN_USER;
    if (r_state == c_ST_CHECK) begin
      if (w_extinct) begin
        w_check_stop   = 1'b1;
        w_check_reason = c_RSN_EXTINCT;
      end else if (w_still) begin
        w_check_stop   = 1'b1;
        w_check_reason = c_RSN_STILL;
      end else if (w_osc2) begin
        w_check_stop   = 1'b1;
        w_check_reason = c_RSN_OSC2;
      end else if (w_limit) begin
        w_check_stop   = 1'b1;
        w_check_reason = c_RSN_LIMIT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            c_OP_LOAD: w_state_nxt = c_ST_LOAD;
            c_OP_STEP: w_state_nxt = c_ST_ADV;
            c_OP_RUN:  w_state_nxt = c_ST_RUN;
            default:   w_state_nxt = c_ST_IDLE;   // STOP while idle is a no-op
          endcase
        end
      end
      c_ST_LOAD: w_state_nxt = c_ST_IDLE;
      c_ST_ADV:  w_state_nxt = c_ST_CHECK;
      c_ST_RUN: begin
        if (w_user_stop) begin
          w_state_nxt = c_ST_IDLE;
        end else if (w_run_adv) begin
          w_state_nxt = c_ST_CHECK;
        end
      end
      c_ST_CHECK: begin
        if (w_check_stop || !r_from_run) begin
          w_state_nxt = c_ST_IDLE;
        end else begin
          w_state_nxt = c_ST_RUN;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // The grid is held by reloading it with its own state; an advance cycle is
  // the only cycle with grid_load low.
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready   = w_ready;
    busy        = (r_state != c_ST_IDLE);
    grid_load   = !w_advance;
    grid_data   = (r_state == c_ST_LOAD) ? r_seed : grid_q;
    // A CHECK stop is reported in the CHECK cycle itself; a user stop shows
    // up in the first idle cycle after the STOP was taken.
    stop_valid  = r_user_stop || w_check_stop;
    stop_reason = w_check_stop ? w_check_reason : r_stop_reason;
  end

  assign gen_count = r_gen_count;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed        <= '0;
      r_prev        <= '0;
      r_gen_count   <= '0;
      r_div_cnt     <= '0;
      r_from_run    <= 1'b0;
      r_user_stop   <= 1'b0;
      r_stop_reason <= c_RSN_USER;
    end else begin
      r_user_stop <= w_user_stop;

      if ((r_state == c_ST_IDLE) && w_accept) begin
        if (cmd_op == c_OP_LOAD) begin
          r_seed <= seed;
        end
        if (cmd_op == c_OP_RUN) begin
          r_div_cnt <= '0;
        end
      end

      if (r_state == c_ST_LOAD) begin
        r_gen_count <= '0;
      end

      if (w_advance) begin
        r_prev     <= grid_q;
        r_from_run <= (r_state == c_ST_RUN);
        if (r_gen_count != '1) begin
          r_gen_count <= r_gen_count + 1'b1;
        end
      end

      // The rate divider counts RUN cycles only; a STOP cycle leaves it alone.
      if ((r_state == c_ST_RUN) && !w_user_stop) begin
        if (w_run_adv) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end

      if (r_state == c_ST_CHECK) begin
        r_div_cnt <= '0;
        if (w_check_stop) begin
          r_stop_reason <= w_check_reason;
        end
      end

      if (w_user_stop) begin
        r_stop_reason <= c_RSN_USER;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_life_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_life_sequencer                                          |
// | Description : Self-checking bench for life_sequencer. A behavioural grid |
// |               plant closes the loop; a generation-timeline model checks  |
// |               every output on every cycle, and directed scenarios pin    |
// |               hand-computed results.                                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_life_sequencer;

  localparam int GEN_W  = 32;
  localparam int RATE_W = 24;

  localparam logic [1:0] c_OP_LOAD = 2'd0;
  localparam logic [1:0] c_OP_STEP = 2'd1;
  localparam logic [1:0] c_OP_RUN  = 2'd2;
  localparam logic [1:0] c_OP_STOP = 2'd3;

  // Model activity phases
  localparam int c_P_IDLE = 0;
  localparam int c_P_LOAD = 1;
  localparam int c_P_SADV = 2;
  localparam int c_P_SCHK = 3;
  localparam int c_P_RUN  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [255:0]      seed;
  logic [RATE_W-1:0] rate_div;
  logic [GEN_W-1:0]  gen_limit;
  logic [255:0]      grid_q = '0;
  logic              grid_load;
  logic [255:0]      grid_data;
  logic              busy;
  logic [GEN_W-1:0]  gen_count;
  logic              stop_valid;
  logic [2:0]        stop_reason;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  life_sequencer #(.GEN_W(GEN_W), .RATE_W(RATE_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .seed        (seed),
    .rate_div    (rate_div),
    .gen_limit   (gen_limit),
    .grid_q      (grid_q),
    .grid_load   (grid_load),
    .grid_data   (grid_data),
    .busy        (busy),
    .gen_count   (gen_count),
    .stop_valid  (stop_valid),
    .stop_reason (stop_reason)
  );

  // One Conway generation on a 16x16 torus.
  function automatic logic [255:0] life_next(input logic [255:0] g);
    logic [255:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              cnt += int'(g[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
            end
          end
        end
        n[r * 16 + c] = (cnt == 3) || (cnt == 2 && g[r * 16 + c]);
      end
    end
    return n;
  endfunction

  // Grid plant: free-running life grid with a load port and no enable.
  always @(posedge clk) begin
    grid_q <= grid_load ? grid_data : life_next(grid_q);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model. Generations in RUN are placed on a timeline: with period
  // P = rate_div+2 counted from the first RUN cycle, the advance happens at
  // offset P-2 and the check at offset P-1 of each period.
  // --------------------------------------------------------------------------
  int           m_phase  = c_P_IDLE;
  int           m_cyc    = 0;
  int           m_t0     = 0;
  int           m_checks = 0;        // checks done since LOAD
  logic [255:0] m_seed   = '0;
  logic [255:0] m_grid   = '0;
  logic [255:0] m_prev   = '0;
  logic [255:0] m_prev2  = '0;
  logic [31:0]  m_gen    = '0;
  logic [2:0]   m_reason = '0;
  logic         m_pend   = 1'b0;

  int           pulses      = 0;
  logic [2:0]   last_reason = '0;
  logic [31:0]  last_gen    = '0;

  always @(negedge clk) begin : compare
    logic       e_busy, e_ready, adv, chk, stopc, accept;
    logic [2:0] rsn;
    int         per, ph;

    if (stop_valid === 1'b1) begin
      pulses++;
      last_reason = stop_reason;
      last_gen    = gen_count;
    end

    if (!rst_n) begin
      m_phase = c_P_IDLE; m_gen = '0; m_reason = '0; m_pend = 1'b0;
      m_seed = '0; m_checks = 0; m_prev = '0; m_prev2 = '0;
      check("rst_busy",       busy,       1'b0);
      check("rst_grid_load",  grid_load,  1'b1);
      check("rst_stop_valid", stop_valid, 1'b0);
      check("rst_gen_count",  gen_count,  '0);
      check("rst_grid_q",     grid_q,     m_grid);
    end else begin
      per = int'(rate_div) + 2;
      ph  = (m_cyc - m_t0) % per;
      adv = 1'b0; chk = 1'b0; stopc = 1'b0; rsn = m_reason;
      e_busy = 1'b1; e_ready = 1'b0;
      case (m_phase)
        c_P_IDLE: begin e_busy = 1'b0; e_ready = 1'b1; end
        c_P_SADV: adv = 1'b1;
        c_P_SCHK: chk = 1'b1;
        c_P_RUN: begin
          chk     = (ph == per - 1);
          e_ready = !chk;
          adv     = !chk && (ph == per - 2) && !(cmd_valid && cmd_op == c_OP_STOP);
        end
        default: ;
      endcase

      if (chk) begin
        if (m_grid == '0) begin
          stopc = 1'b1; rsn = 3'd1;
        end else if (m_grid == m_prev) begin
          stopc = 1'b1; rsn = 3'd2;
`ifdef LIFE_OSC2_DETECT_EN
        end else if (m_checks > 0 && m_grid == m_prev2) begin
          stopc = 1'b1; rsn = 3'd4;
`endif
        end else if (m_phase == c_P_RUN && gen_limit != 0 && m_gen >= gen_limit) begin
          stopc = 1'b1; rsn = 3'd3;
        end
      end

      check("busy",        busy,        e_busy);
      check("cmd_ready",   cmd_ready,   e_ready);
      check("grid_load",   grid_load,   !adv);
      if (!adv) begin
        check("grid_data", grid_data, (m_phase == c_P_LOAD) ? m_seed : m_grid);
      end
      check("grid_q",      grid_q,      m_grid);
      check("gen_count",   gen_count,   m_gen);
      check("stop_valid",  stop_valid,  stopc || m_pend);
      check("stop_reason", stop_reason, stopc ? rsn : m_reason);

      // Advance the model to the next cycle.
      accept = cmd_valid && e_ready;
      m_pend = 1'b0;
      case (m_phase)
        c_P_IDLE: begin
          if (accept) begin
            case (cmd_op)
              c_OP_LOAD: begin m_seed = seed; m_phase = c_P_LOAD; end
              c_OP_STEP: m_phase = c_P_SADV;
              c_OP_RUN:  begin m_phase = c_P_RUN; m_t0 = m_cyc + 1; end
              default: ;
            endcase
          end
        end
        c_P_LOAD: begin
          m_grid = m_seed; m_gen = '0; m_checks = 0; m_phase = c_P_IDLE;
        end
        c_P_SADV: begin
          m_prev = m_grid; m_grid = life_next(m_grid);
          if (m_gen != '1) m_gen++;
          m_phase = c_P_SCHK;
        end
        c_P_SCHK: begin
          if (stopc) m_reason = rsn;
          m_prev2 = m_prev; m_checks++;
          m_phase = c_P_IDLE;
        end
        default: begin // RUN
          if (chk) begin
            m_prev2 = m_prev; m_checks++;
            if (stopc) begin m_reason = rsn; m_phase = c_P_IDLE; end
          end else if (accept && cmd_op == c_OP_STOP) begin
            m_phase = c_P_IDLE; m_pend = 1'b1; m_reason = 3'd0;
          end else if (adv) begin
            m_prev = m_grid; m_grid = life_next(m_grid);
            if (m_gen != '1) m_gen++;
          end
        end
      endcase
    end
    m_cyc++;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers; each starts and ends 1 time unit after a rising edge.
  // --------------------------------------------------------------------------
  task automatic issue(input logic [1:0] op);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_op%0d: cmd_ready stayed 0 for 50 cycles, expected 1", op);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit done = 0;
    for (int n = 0; n < max && !done; n++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", max);
    end
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  logic [255:0] block, single, blink_h, blink_v;
  int p0;

  initial begin
    block   = '0; block[0] = 1'b1; block[1] = 1'b1; block[16] = 1'b1; block[17] = 1'b1;
    single  = '0; single[0] = 1'b1;
    blink_h = '0; blink_h[17] = 1'b1; blink_h[18] = 1'b1; blink_h[19] = 1'b1;
    blink_v = '0; blink_v[2]  = 1'b1; blink_v[18] = 1'b1; blink_v[34] = 1'b1;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; seed = '0; rate_div = '0; gen_limit = '0;

    // Pin the grid model against hand-derived patterns.
    check("model_block",   life_next(block),   block);
    check("model_single",  life_next(single),  '0);
    check("model_blink_h", life_next(blink_h), blink_v);
    check("model_blink_v", life_next(blink_v), blink_h);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy",   busy,        1'b0);
    check("reset_ready",  cmd_ready,   1'b1);
    check("reset_gen",    gen_count,   '0);
    check("reset_reason", stop_reason, 3'd0);
    check("reset_load",   grid_load,   1'b1);
    @(posedge clk); #1;

    // STOP while idle: accepted, no pulse.
    p0 = pulses;
    issue(c_OP_STOP); settle();
    check("idle_stop_pulses", pulses - p0, 0);

    // Block still life under STEP.
    seed = block; issue(c_OP_LOAD); wait_idle(10);
    p0 = pulses;
    issue(c_OP_STEP); wait_idle(10); settle();
    check("block_pulses", pulses - p0, 1);
    check("block_reason", last_reason, 3'd2);
    check("block_gen",    gen_count,   32'd1);
    check("block_grid",   grid_q,      block);
    check("block_busy",   busy,        1'b0);

    // Single cell dies.
    seed = single; issue(c_OP_LOAD); wait_idle(10);
    issue(c_OP_STEP); wait_idle(10); settle();
    check("single_reason", last_reason, 3'd1);
    check("single_gen",    last_gen,    32'd1);
    check("single_grid",   grid_q,      '0);

    // Blinker free-run, rate_div=3, gen_limit=5.
    seed = blink_h; rate_div = 24'd3; gen_limit = 32'd5;
    issue(c_OP_LOAD); wait_idle(10);
    p0 = pulses;
    issue(c_OP_RUN); wait_idle(200); settle();
    check("blink_pulses", pulses - p0, 1);
`ifdef LIFE_OSC2_DETECT_EN
    check("blink_reason", last_reason, 3'd4);
    check("blink_gen",    last_gen,    32'd2);
    check("blink_grid",   grid_q,      blink_h);
`else
    check("blink_reason", last_reason, 3'd3);
    check("blink_gen",    last_gen,    32'd5);
    check("blink_grid",   grid_q,      blink_v);
`endif

    // STOP taken in a RUN cycle that would otherwise advance.
    rate_div = 24'd0; gen_limit = 32'd0;
    issue(c_OP_LOAD); wait_idle(10);
    p0 = pulses;
    issue(c_OP_RUN);
    issue(c_OP_STOP); settle();
    check("ustop_pulses", pulses - p0, 1);
    check("ustop_reason", last_reason, 3'd0);
    check("ustop_gen",    gen_count,   32'd0);
    check("ustop_grid",   grid_q,      blink_h);

    // STOP held through CHECK is taken in the following RUN cycle.
    rate_div = 24'd2;
    issue(c_OP_LOAD); wait_idle(10);
    p0 = pulses;
    issue(c_OP_RUN);
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_op = c_OP_STOP;
    @(negedge clk);
    check("chk_ready", cmd_ready, 1'b0);
    check("chk_busy",  busy,      1'b1);
    @(posedge clk); #1;
    issue(c_OP_STOP); settle();
    check("chkstop_pulses", pulses - p0, 1);
    check("chkstop_reason", last_reason, 3'd0);
    check("chkstop_gen",    gen_count,   32'd1);
    check("chkstop_grid",   grid_q,      blink_v);

    // Asynchronous reset in the middle of a RUN.
    rate_div = 24'd1; seed = blink_h;
    issue(c_OP_LOAD); wait_idle(10);
    issue(c_OP_RUN);
    repeat (7) @(posedge clk);
    #1;
    p0 = pulses;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_busy",  busy,       1'b0);
    check("mrst_gen",   gen_count,  '0);
    check("mrst_load",  grid_load,  1'b1);
    check("mrst_stopv", stop_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mrst_grid", grid_q, blink_h);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_pulses", pulses - p0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
